// File: rtl/mfe_window_fetch.sv
// rtl/mfe_window_fetch.sv - 3x3 neighbourhood fetcher for the median-filter engine
//
// Walks a IMG_W x IMG_H greyscale image in raster order through a zero-wait
// ROM port and presents one 3x3 window per pixel over a valid/ready handshake.
// Each window costs 3 fetch cycles plus at least 1 emit cycle. Each row adds
// 3 column-0 fetch cycles at its start.
//
// Ports:
//   clk, reset  - single clock; asynchronous active-high reset
//   ready       - frame-start request, sampled only while idle
//   busy        - frame in progress (cycle after accept .. final handshake)
//   iaddr/idata - ROM address (y*IMG_W + x) and same-cycle read data
//   win_valid   - window presented; win_ready - sorter accepts it
//   win_data    - w0..w8 raster order, w0 (y-1,x-1) in the MSBs
//   win_addr    - address of the centre pixel (y,x)
//
// Compile option MFE_WIN_REPLICATE_EN: out-of-range rows/columns are clamped
// to the nearest edge (replicate padding) instead of reading as zero.
module mfe_window_fetch #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ready,
  output logic            busy,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [AW-1:0]   win_addr
);

  localparam int CW = AW / 2;
  localparam int XB = $clog2(IMG_W);
  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, ROW_INIT, FETCH, EMIT} state_t;

  state_t                 state;
  logic [1:0]             k;
  logic [CW-1:0]          x;
  logic [CW-1:0]          y;
  logic [2:0][DW-1:0]     col_l;
  logic [2:0][DW-1:0]     col_c;
  logic [2:0][DW-1:0]     col_r;
  logic [AW-1:0]          addr_hold;

  logic                   fetch_cyc;
  logic                   row_under;
  logic                   row_over;
  logic                   col_over;
  logic [CW-1:0]          row_raw;
  logic [CW-1:0]          col_raw;
  logic [CW-1:0]          rd_row;
  logic [CW-1:0]          rd_col;
  logic                   rd_pad;
  logic [AW-1:0]          rd_addr;
  logic [DW-1:0]          rd_val;
  logic [DW-1:0]          l_val;

  // Row/column targeted by the current fetch cycle. Fetch cycle k covers row
  // y-1+k; ROW_INIT reads column 0, FETCH reads column x+1.
  always_comb begin
    fetch_cyc = (state == ROW_INIT) || (state == FETCH);
    row_under = (k == 2'd0) && (y == '0);
    row_over  = (k == 2'd2) && (y == Y_LAST);
    col_over  = (state == FETCH) && (x == X_LAST);
    case (k)
      2'd0:    row_raw = y - ONE;
      2'd1:    row_raw = y;
      default: row_raw = y + ONE;
    endcase
    col_raw = (state == FETCH) ? (x + ONE) : '0;
`ifdef MFE_WIN_REPLICATE_EN
    rd_pad = 1'b0;
    rd_row = row_under ? '0 : (row_over ? Y_LAST : row_raw);
    rd_col = col_over ? X_LAST : col_raw;
`else
    // The wrapped row_raw/col_raw values are never used when padding.
    rd_pad = row_under || row_over || col_over;
    rd_row = row_raw;
    rd_col = col_raw;
`endif
  end

  assign rd_addr = (AW'(rd_row) << XB) | AW'(rd_col);
  assign rd_val  = rd_pad ? '0 : idata;
`ifdef MFE_WIN_REPLICATE_EN
  assign l_val   = rd_val;
`else
  assign l_val   = '0;
`endif

  // The address bus only moves on real reads; pad and non-fetch cycles keep
  // the last issued address.
  assign iaddr    = (fetch_cyc && !rd_pad) ? rd_addr : addr_hold;
  assign win_addr = (AW'(y) << XB) | AW'(x);
  assign win_data = {col_l[0], col_c[0], col_r[0],
                     col_l[1], col_c[1], col_r[1],
                     col_l[2], col_c[2], col_r[2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      x         <= '0;
      y         <= '0;
      col_l     <= '0;
      col_c     <= '0;
      col_r     <= '0;
      addr_hold <= '0;
      busy      <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      if (fetch_cyc && !rd_pad) begin
        addr_hold <= rd_addr;
      end
      case (state)
        IDLE: begin
          if (ready) begin
            state <= ROW_INIT;
            k     <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
          end
        end
        ROW_INIT: begin
          col_c[k] <= rd_val;
          col_l[k] <= l_val;
          if (k == 2'd2) begin
            k     <= '0;
            state <= FETCH;
          end else begin
            k <= k + 2'd1;
          end
        end
        FETCH: begin
          col_r[k] <= rd_val;
          if (k == 2'd2) begin
            k         <= '0;
            state     <= EMIT;
            win_valid <= 1'b1;
          end else begin
            k <= k + 2'd1;
          end
        end
        EMIT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            col_l     <= col_c;
            col_c     <= col_r;
            if (x != X_LAST) begin
              x     <= x + ONE;
              state <= FETCH;
            end else if (y != Y_LAST) begin
              x     <= '0;
              y     <= y + ONE;
              state <= ROW_INIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfe_window_fetch.sv
// tb/tb_mfe_window_fetch.sv - self-checking bench for mfe_window_fetch
module tb_mfe_window_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [13:0] iaddr;
  logic [7:0]  idata;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [13:0] win_addr;

  logic [7:0]  mem [0:16383];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  assign idata = mem[iaddr];

  mfe_window_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_addr  (win_addr)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
`ifdef MFE_WIN_REPLICATE_EN
    if (r < 0) r = 0;
    if (r > 127) r = 127;
    if (c < 0) c = 0;
    if (c > 127) c = 127;
`else
    if (r < 0 || r > 127 || c < 0 || c > 127) return 8'h00;
`endif
    return mem[r * 128 + c];
  endfunction

  function automatic logic [71:0] win_exp(input int n);
    int y = n / 128;
    int x = n % 128;
    logic [71:0] w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[63:0], pix(y + dr, x + dc)};
    return w;
  endfunction

  // Runs a frame from a ready request. stop_n >= 0 returns while window
  // stop_n is being held; stall_n holds that window for 5 cycles.
  task automatic run_frame(input int stop_n, input bit rnd, input int stall_n, input int pulse_cyc);
    int cyc = 0;
    int n = 0;
    int busy_cyc = 0;
    int hold = 0;
    bit done = 0;
    bit seen = 0;
    logic [71:0] sd;
    logic [13:0] sa;
    logic [13:0] si;
    @(negedge clk);
    ready = 1'b1;
    win_ready = 1'b0;
    while (!done && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      ready = (cyc == pulse_cyc);
      if (cyc == 1) chk("busy_rise", 72'(busy), 72'(1));
      if (busy) busy_cyc++;
      if (!busy) begin
        done = 1;
        chk("valid_at_busy_fall", 72'(win_valid), 72'(0));
      end else begin
        if (win_valid && !seen) begin
          seen = 1;
          chk("first_latency", 72'(cyc - 1), 72'(6));
        end
        if (win_valid && n == stop_n) begin
          win_ready = 1'b0;
          done = 1;
        end else if (win_valid && n == stall_n && hold < 5) begin
          win_ready = 1'b0;
          hold++;
          if (hold == 1) begin
            sd = win_data;
            sa = win_addr;
            si = iaddr;
          end else begin
            chk("stall_data", win_data, sd);
            chk("stall_addr", 72'(win_addr), 72'(sa));
            chk("stall_iaddr", 72'(iaddr), 72'(si));
          end
        end else begin
          win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (win_valid && win_ready) begin
            chk("win_data", win_data, win_exp(n));
            chk("win_addr", 72'(win_addr), 72'(n));
            n++;
          end
        end
      end
    end
    if (!done) begin
      chk("timeout", 72'(0), 72'(1));
    end else if (stop_n < 0) begin
      chk("handshakes", 72'(n), 72'(16384));
      chk("busy_cycles", 72'(busy_cyc), 72'(65920 + hold));
    end
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    win_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_iaddr", 72'(iaddr), 72'(0));
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_data", win_data, 72'(0));
    chk("rst_waddr", 72'(win_addr), 72'(0));
    reset = 1'b0;

    for (int a = 0; a < 16384; a++) mem[a] = 8'((a / 128 + a % 128) & 8'hFF);

    // Full frame, win_ready high, 5-cycle stall at window 200, ready pulse mid-frame.
    run_frame(-1, 1'b0, 200, 1000);
    repeat (5) @(negedge clk);
    chk("idle_busy", 72'(busy), 72'(0));
    chk("idle_valid", 72'(win_valid), 72'(0));

    // Random image and random back-pressure; reset while window 500 is held.
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    run_frame(500, 1'b1, -1, 0);
    chk("hold_valid", 72'(win_valid), 72'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_valid", 72'(win_valid), 72'(0));
    chk("mid_rst_data", win_data, 72'(0));
    chk("mid_rst_waddr", 72'(win_addr), 72'(0));
    chk("mid_rst_iaddr", 72'(iaddr), 72'(0));
    @(negedge clk);
    reset = 1'b0;

    // Restart from (0,0) with a ready pulse while busy.
    run_frame(300, 1'b1, -1, 50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
